// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_op_sequencer                                                           |
// | Issue/collect stage in front of the fp_subtract core: DAZ, ADD->SUB sign   |
// | flip, a single start pulse, fixed-latency capture and result handshake.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_op_sequencer #(
   parameter int CORE_LAT = 4,
   parameter int CNT_W    = 16,
   parameter int DAZ_EN   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic             in_op,
   output logic [31:0]      core_a,
   output logic [31:0]      core_b,
   output logic             core_valid,
   input  logic [31:0]      core_diff,
   input  logic             core_error,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_error,
   output logic [4:0]       out_flags,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic             daz_q;

   logic        a_den, b_den;
   logic [31:0] a_fl, b_fl;
   logic        res_exp_ff, res_exp_00, res_man_00;

   // Denormal: exponent zero with a non-zero mantissa; flushed to signed zero.
   assign a_den = (DAZ_EN != 0) && (in_a[30:23] == 8'h00) && (in_a[22:0] != 23'h0);
   assign b_den = (DAZ_EN != 0) && (in_b[30:23] == 8'h00) && (in_b[22:0] != 23'h0);
   assign a_fl  = a_den ? {in_a[31], 31'b0} : in_a;
   assign b_fl  = b_den ? {in_b[31], 31'b0} : in_b;

   assign res_exp_ff = (core_diff[30:23] == 8'hFF);
   assign res_exp_00 = (core_diff[30:23] == 8'h00);
   assign res_man_00 = (core_diff[22:0] == 23'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lat_cnt    <= '0;
         daz_q      <= 1'b0;
         in_ready   <= 1'b1;
         core_a     <= '0;
         core_b     <= '0;
         core_valid <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_error  <= 1'b0;
         out_flags  <= '0;
         busy       <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // The core only subtracts, so ADD is issued as A - (-B).
                  core_a     <= a_fl;
                  core_b     <= b_fl ^ {in_op, 31'b0};
                  daz_q      <= a_den | b_den;
                  in_ready   <= 1'b0;
                  core_valid <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               core_valid <= 1'b0;
               lat_cnt    <= LAT_LOAD;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - 1'b1;
               end else begin
                  out_result <= core_diff;
                  out_error  <= core_error;
                  out_flags  <= {daz_q,
                                 res_exp_ff & ~res_man_00,
                                 res_exp_ff &  res_man_00,
                                 res_exp_00 &  res_man_00,
                                 core_diff[31]};
                  out_valid  <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  op_count  <= op_count + 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state      <= ST_IDLE;
               in_ready   <= 1'b1;
               core_valid <= 1'b0;
               out_valid  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fpu_op_sequencer                                                        |
// | Directed bench with a fixed-latency core stand-in.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fpu_op_sequencer;

   localparam int CORE_LAT = 4;
   localparam int CNT_W    = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = '0;
   logic [31:0]      in_b = '0;
   logic             in_op = 1'b0;
   logic [31:0]      core_a, core_b;
   logic             core_valid;
   logic [31:0]      core_diff;
   logic             core_error;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_result;
   logic             out_error;
   logic [4:0]       out_flags;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0;
   int cv0;
   int n;
   logic [31:0] res_hold;
   logic [31:0] a_hold;
   logic [4:0]  flg_hold;
   logic        seen_valid;

   // Core stand-in: result is only meaningful exactly CORE_LAT cycles after the pulse.
   logic [CORE_LAT-1:0] pipe = '0;
   logic [31:0]         core_res = '0;
   logic                core_err = 1'b0;
   assign core_diff  = pipe[CORE_LAT-1] ? core_res : 32'hDEADBEEF;
   assign core_error = pipe[CORE_LAT-1] ? core_err : 1'b1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe <= {pipe[CORE_LAT-2:0], core_valid};
      if (core_valid) cv_cnt <= cv_cnt + 1;
   end

   fpu_op_sequencer #(.CORE_LAT(CORE_LAT), .CNT_W(CNT_W), .DAZ_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .core_a(core_a), .core_b(core_b), .core_valid(core_valid),
      .core_diff(core_diff), .core_error(core_error),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_error(out_error), .out_flags(out_flags),
      .busy(busy), .op_count(op_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a negedge with in_ready high; returns in the ISSUE cycle.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] diff, input logic err);
      core_res = diff;
      core_err = err;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      cv0 = cv_cnt;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts cycles from accept (cycle 0) until out_valid is seen, bounded.
   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] diff, input logic err,
                          input logic [31:0] exp_ca, input logic [31:0] exp_cb,
                          input logic [4:0] exp_flags, input logic [15:0] exp_cnt);
      int cyc;
      launch(a, b, op, diff, err);
      chk({tag, ".core_valid"}, 32'(core_valid), 32'd1);
      chk({tag, ".in_ready"},   32'(in_ready),   32'd0);
      chk({tag, ".busy"},       32'(busy),       32'd1);
      chk({tag, ".core_a"},     core_a,          exp_ca);
      chk({tag, ".core_b"},     core_b,          exp_cb);
      wait_out(cyc);
      chk({tag, ".latency"},    32'(cyc),        32'(CORE_LAT + 2));
      chk({tag, ".result"},     out_result,      diff);
      chk({tag, ".error"},      32'(out_error),  32'(err));
      chk({tag, ".flags"},      32'(out_flags),  32'(exp_flags));
      @(negedge clk);
      chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
      chk({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
      chk({tag, ".op_count"},        32'(op_count),  32'(exp_cnt));
      chk({tag, ".pulses"},          32'(cv_cnt - cv0), 32'd1);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.in_ready",   32'(in_ready),   32'd1);
      chk("rst.out_valid",  32'(out_valid),  32'd0);
      chk("rst.busy",       32'(busy),       32'd0);
      chk("rst.core_valid", 32'(core_valid), 32'd0);
      chk("rst.op_count",   32'(op_count),   32'd0);
      chk("rst.out_flags",  32'(out_flags),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 3.0 - 1.0 = 2.0
      full_op("sub", 32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0,
              32'h40400000, 32'h3F800000, 5'b00000, 16'd1);
      // 1.5 + 2.5 = 4.0, issued with B negated
      full_op("add", 32'h3FC00000, 32'h40200000, 1'b1, 32'h40800000, 1'b0,
              32'h3FC00000, 32'hC0200000, 5'b00000, 16'd2);
      // NaN operand: core flags error, result is a NaN
      full_op("nan", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FFFFFFF, 1'b1,
              32'h7FC00000, 32'h3F800000, 5'b01000, 16'd3);
      // Denormal A flushed: 0 - 1.0 = -1.0, daz and neg set
      full_op("daz", 32'h00000001, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0,
              32'h00000000, 32'h3F800000, 5'b10001, 16'd4);
      // Subtraction giving +0: zero flag
      full_op("zero", 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0,
              32'h3F800000, 32'h3F800000, 5'b00010, 16'd5);
      // Overflow to +inf
      full_op("inf", 32'h7F7FFFFF, 32'hFF7FFFFF, 1'b0, 32'h7F800000, 1'b0,
              32'h7F7FFFFF, 32'hFF7FFFFF, 5'b00100, 16'd6);

      // Backpressure: hold DONE for 10 cycles while pushing ignored requests
      out_ready = 1'b0;
      launch(32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
      wait_out(n);
      chk("bp.latency", 32'(n), 32'(CORE_LAT + 2));
      res_hold = out_result;
      flg_hold = out_flags;
      a_hold   = core_a;
      chk("bp.result", res_hold, 32'h40000000);
      in_valid = 1'b1;
      in_a     = 32'h12345678;
      in_b     = 32'h87654321;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp.out_valid", 32'(out_valid),  32'd1);
         chk("bp.in_ready",  32'(in_ready),   32'd0);
         chk("bp.stable",    out_result,      32'h40000000);
         chk("bp.flags",     32'(out_flags),  32'(flg_hold));
         chk("bp.core_a",    core_a,          32'h40400000);
      end
      chk("bp.pulses", 32'(cv_cnt - cv0), 32'd1);
      chk("bp.count_held", 32'(op_count), 32'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.count",     32'(op_count),  32'd7);
      chk("bp.idle",      32'(busy),      32'd0);
      chk("bp.in_ready",  32'(in_ready),  32'd1);
      chk("bp.out_valid_after", 32'(out_valid), 32'd0);

      // Reset in WAIT aborts the op
      launch(32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rw.busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw.in_ready",  32'(in_ready),  32'd1);
      chk("rw.out_valid", 32'(out_valid), 32'd0);
      chk("rw.op_count",  32'(op_count),  32'd0);
      chk("rw.busy",      32'(busy),      32'd0);
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      chk("rw.no_late", 32'(seen_valid), 32'd0);
      chk("rw.result",  out_result,     32'h00000000);

      // Works normally after the abort
      full_op("post", 32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0,
              32'h40400000, 32'h3F800000, 5'b00000, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
